// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 multiply/divide unit that runs beside the execute-stage ALU.
// Define MULDIV_ACC_EN for MADD/MADDU/MSUB/MSUBU; otherwise op_i[2]=1 passes {hi_i,lo_i} straight through.
module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o,
    output logic                  div_zero_o
);
    localparam int RES_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic                op_div_q, op_div_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [RES_W-1:0]    acc_q, acc_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                ready_q, ready_d;
    logic                div_zero_q, div_zero_d;
`ifdef MULDIV_ACC_EN
    logic [RES_W-1:0]    hilo_q, hilo_d;
    logic                mac_q, mac_d;
    logic                msub_q, msub_d;
`endif

    logic                op_signed, a_neg, b_neg, op_is_div;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic [RES_W-1:0]    prod_fix, fix_res;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    // Operand conditioning: signed ops work on magnitudes; -2^(W-1) negates to its own unsigned magnitude.
    always_comb begin
        op_signed = ~op_i[0];
        op_is_div = (op_i[2:1] == 2'b01);
        a_neg     = op_signed & opdata1_i[DATA_W-1];
        b_neg     = op_signed & opdata2_i[DATA_W-1];
        a_abs     = a_neg ? -opdata1_i : opdata1_i;
        b_abs     = b_neg ? -opdata2_i : opdata2_i;
    end

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[RES_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : {(DATA_W+1){1'b0}});
        div_shift = acc_q[RES_W-1:DATA_W-1];
        div_diff  = div_shift - {1'b0, b_q};
        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quot_fix  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem_fix   = neg_rem_q ? -acc_q[RES_W-1:DATA_W] : acc_q[RES_W-1:DATA_W];
        fix_res   = prod_fix;
        if (op_div_q) begin
            fix_res = {rem_fix, quot_fix};
        end
`ifdef MULDIV_ACC_EN
        else if (mac_q) begin
            fix_res = msub_q ? (hilo_q - prod_fix) : (hilo_q + prod_fix);
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        op_div_d   = op_div_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        ready_d    = ready_q;
        div_zero_d = div_zero_q;
`ifdef MULDIV_ACC_EN
        hilo_d     = hilo_q;
        mac_d      = mac_q;
        msub_d     = msub_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    op_div_d   = op_is_div;
                    a_d        = op_is_div ? a_abs : a_abs;
                    b_d        = b_abs;
                    acc_d      = {{DATA_W{1'b0}}, (op_is_div ? a_abs : b_abs)};
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    state_d    = RUN;
                    if (op_i[2]) begin
`ifdef MULDIV_ACC_EN
                        hilo_d = {hi_i, lo_i};
                        mac_d  = 1'b1;
                        msub_d = op_i[1];
`else
                        result_d = {hi_i, lo_i};
                        ready_d  = 1'b1;
                        state_d  = DONE;
`endif
                    end else begin
`ifdef MULDIV_ACC_EN
                        mac_d  = 1'b0;
                        msub_d = 1'b0;
`endif
                        if (op_is_div && (opdata2_i == '0)) begin
                            result_d   = {opdata1_i, {DATA_W{1'b1}}};
                            div_zero_d = 1'b1;
                            ready_d    = 1'b1;
                            state_d    = DONE;
                        end
                    end
                end
            end
            RUN: begin
                if (op_div_q) begin
                    acc_d = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                             : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                end
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                result_d = fix_res;
                ready_d  = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                // Holding start_i parks the unit here so a level start cannot relaunch.
                if (!start_i) begin
                    ready_d    = 1'b0;
                    div_zero_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (annul_i) begin
            state_d    = IDLE;
            ready_d    = 1'b0;
            div_zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_div_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_ACC_EN
            hilo_q     <= '0;
            mac_q      <= 1'b0;
            msub_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_div_q   <= op_div_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            ready_q    <= ready_d;
            div_zero_q <= div_zero_d;
`ifdef MULDIV_ACC_EN
            hilo_q     <= hilo_d;
            mac_q      <= mac_d;
            msub_q     <= msub_d;
`endif
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign div_zero_o = div_zero_q;
    assign stallreq_o = ~annul_i & (((state_q == IDLE) & start_i) | (state_q == RUN) | (state_q == FIX));

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv (DATA_W=32): latency, signed/unsigned results, divide-by-zero,
// annul, held start, mid-operation reset and the op_i[2] path (accumulate when MULDIV_ACC_EN is defined).
module tb_ex_muldiv;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           annul_i;
    logic [2:0]     op_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic [W-1:0]   hi_i;
    logic [W-1:0]   lo_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           stallreq_o;
    logic           div_zero_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [2*W-1:0] exp_q[$];

    ex_muldiv #(.DATA_W(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op, wait for ready_o (bounded), check latency/result/flags, hold start for 'hold' extra cycles.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [2*W-1:0] exp_res,
                          input int exp_lat, input logic exp_dz, input int hold);
        int lat;
        logic stall_ok;
        logic [2*W-1:0] exp_v;
        exp_q.push_back(exp_res);
        @(negedge clk);
        op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi; lo_i = lo; start_i = 1'b1;
        #1 chk({tag, " stall_c0"}, stallreq_o, 1);
        lat = 0;
        stall_ok = 1'b1;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            opdata1_i = $urandom; opdata2_i = $urandom; hi_i = $urandom; lo_i = $urandom;
            if (ready_o) break;
            if (!stallreq_o) stall_ok = 1'b0;
        end
        exp_v = exp_q.pop_front();
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, result_o, exp_v);
        chk({tag, " div_zero"}, div_zero_o, exp_dz);
        chk({tag, " stall_busy"}, stall_ok, 1);
        chk({tag, " stall_done"}, stallreq_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold_ready"}, ready_o, 1);
            chk({tag, " hold_result"}, result_o, exp_v);
            chk({tag, " hold_stall"}, stallreq_o, 0);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1 chk({tag, " ready_clear"}, ready_o, 0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 3'b000;
        opdata1_i = '0; opdata2_i = '0; hi_i = '0; lo_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result_o, 0);
        chk("reset ready", ready_o, 0);
        chk("reset div_zero", div_zero_o, 0);
        chk("reset stall", stallreq_o, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mult_neg3x5",  3'b000, 32'hFFFF_FFFD, 32'd5,        '0, '0, 64'hFFFF_FFFF_FFFF_FFF1, 34, 1'b0, 0);
        run_op("div_m7_2",     3'b010, 32'hFFFF_FFF9, 32'd2,        '0, '0, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b0, 0);
        run_op("divu_m7_2",    3'b011, 32'hFFFF_FFF9, 32'd2,        '0, '0, 64'h0000_0001_7FFF_FFFC, 34, 1'b0, 0);
        run_op("div_7_m2",     3'b010, 32'd7,         32'hFFFF_FFFE, '0, '0, 64'h0000_0001_FFFF_FFFD, 34, 1'b0, 0);
        run_op("divu_by0",     3'b011, 32'h0000_1234, 32'd0,        '0, '0, 64'h0000_1234_FFFF_FFFF, 1,  1'b1, 0);
        run_op("div_by0",      3'b010, 32'hFFFF_FFF0, 32'd0,        '0, '0, 64'hFFFF_FFF0_FFFF_FFFF, 1,  1'b1, 0);
        run_op("mult_minxmin", 3'b000, 32'h8000_0000, 32'h8000_0000, '0, '0, 64'h4000_0000_0000_0000, 34, 1'b0, 0);
        run_op("mult_minx1",   3'b000, 32'h8000_0000, 32'd1,        '0, '0, 64'hFFFF_FFFF_8000_0000, 34, 1'b0, 0);
        run_op("div_min_m1",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, 64'h0000_0000_8000_0000, 34, 1'b0, 0);
        run_op("multu_minx2",  3'b001, 32'h8000_0000, 32'd2,        '0, '0, 64'h0000_0001_0000_0000, 34, 1'b0, 0);

        // Annul mid-RUN at cycle 10, with start still held so annul priority is exercised.
        @(negedge clk);
        op_i = 3'b001; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'hFFFF_FFFF; start_i = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1 chk("annul stall_run", stallreq_o, 0);
        @(posedge clk);
        #1;
        chk("annul ready", ready_o, 0);
        chk("annul stall_idle", stallreq_o, 0);
        chk("annul result_kept", result_o, 64'h0000_0001_0000_0000);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("annul no_complete", ready_o, 0);
        run_op("multu_max_relaunch", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, 64'hFFFF_FFFE_0000_0001, 34, 1'b0, 5);

`ifdef MULDIV_ACC_EN
        run_op("madd", 3'b100, 32'd3, 32'hFFFF_FFFC, 32'd0, 32'd10, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1'b0, 0);
        run_op("msubu", 3'b111, 32'd2, 32'd3, 32'd0, 32'd1, 64'hFFFF_FFFF_FFFF_FFFB, 34, 1'b0, 0);
`else
        run_op("madd_noop", 3'b100, 32'd3, 32'hFFFF_FFFC, 32'd0, 32'd10, 64'h0000_0000_0000_000A, 1, 1'b0, 0);
`endif

        // Reset asserted mid-RUN must clear every output at once.
        @(negedge clk);
        op_i = 3'b000; opdata1_i = 32'd9; opdata2_i = 32'd9; start_i = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        #1;
        chk("midrst result", result_o, 0);
        chk("midrst ready", ready_o, 0);
        chk("midrst stall", stallreq_o, 0);
        chk("midrst div_zero", div_zero_o, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu_after_rst", 3'b011, 32'd100, 32'd7, '0, '0, 64'h0000_0002_0000_000E, 34, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
